uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Output stage sitting directly downstream of the user core inside the tt_um project wrapper.
- Consumes 8-bit result bytes from the core over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte onto one uo_out pin as an 8N1 UART frame, with optional even parity, so results can be observed with a single pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; integer >= 2.
- FIFO_DEPTH, 4, buffer entries; power of two, >= 2.
- PARITY_EN, 0, 1 inserts an even-parity bit between the data bits and the stop bit.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset; synchronous, active-high. The wrapper drives it as ~rst_n.
- in_data  input  8  byte from the core.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a byte; equals !full, forced 0 while rst=1.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - tx=1, busy=0, fifo_level=0.
  - FIFO pointers cleared; FSM returns to IDLE; bit and baud counters cleared.
  - Applies immediately, including mid-frame. Any partial frame is abandoned and tx returns high on the next cycle. No glitch or extra bits follow.
- Push:
  - Occurs when in_valid && in_ready at a clk edge.
  - in_ready reflects the registered full flag only. When the FIFO is full, a pop in the same cycle does not enable a push.
  - A byte presented while in_ready=0 is not taken. Holding it is the core's job; no overflow is possible.
- Pop: occurs when the FSM is in IDLE, or on the last cycle of STOP, and the FIFO is non-empty. The popped byte is loaded into the shift register.
- Simultaneous push and pop with a non-full FIFO: fifo_level is unchanged.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - PARITY: only when PARITY_EN=1; tx = XOR of the 8 data bits, CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - End of STOP: if the FIFO is non-empty, pop and go straight to START with no idle gap; else go to IDLE.
- Latency: a byte accepted at edge E0 into an empty, idle block is popped at E1. tx is low from E1 onward, i.e. the start bit begins one cycle after acceptance.
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- tx is driven straight from a flop; no combinational path from inputs to tx.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps. The bit counter counts 0..7 in DATA.
- busy = (state != IDLE) || (fifo_level != 0), registered.
- FIFO wrap: pointers are $clog2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB compare.

Decomposition:
- Shared package tt_uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP; 3 bits).
  - Frame bit-count constants.
  - A function computing the baud counter width from CLKS_PER_BIT.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH).
  - Ports: push/pop, data in/out, full, empty, level.
  - Same clk/rst convention.
  - Reused by later input-side stages.

Test Plan:
- CLKS_PER_BIT=4, PARITY_EN=0; push 0xA5 once:
  - tx low from the cycle after acceptance.
  - Bit sequence, each bit held 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 1.
  - busy falls 40 cycles after the start bit begins.
- PARITY_EN=1; push 0xA5 -> a parity bit of 0 follows the data bits; push 0x07 -> parity bit 1. Frames are 44 cycles each.
- Hold in_valid high with 6 distinct bytes, FIFO_DEPTH=4:
  - in_ready drops when fifo_level=4.
  - All 6 bytes are emitted in order with no idle cycles between frames.
  - No byte is lost or duplicated.
- Push on the same cycle as the end-of-STOP pop with fifo_level=2 -> fifo_level stays 2 and ordering is preserved.
- Assert rst for 1 cycle mid-DATA of 0x3C:
  - tx=1 on the next cycle; fifo_level=0; busy=0.
  - A byte pushed afterwards transmits a clean full frame.
- Idle check: after reset with in_valid=0 for 200 cycles -> tx stays 1, busy 0, in_ready 1.

Source files
------------

// File: rtl/tt_uart_pkg.sv
// Shared definitions for the tt_um UART output stage: FSM encoding, frame sizes and
// baud counter sizing.
package tt_uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam int unsigned DataBits          = 8;
    localparam int unsigned FrameBitsNoParity = DataBits + 2;
    localparam int unsigned FrameBitsParity   = DataBits + 3;

    // Counter must hold 0..clks_per_bit-1; never narrower than one bit.
    function automatic int unsigned baud_cnt_width(input int unsigned clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset. Pointers carry one extra wrap bit
// so full/empty come straight from the registered pointers.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign level_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrOne;
            if (do_pop)  rptr_q <= rptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers result bytes from the core and serialises them as 8N1 (optionally 8E1) UART
// frames on a single registered output pin.
module uart_tx_fifo
    import tt_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned     BaudW    = baud_cnt_width(CLKS_PER_BIT);
    localparam int unsigned     LvlW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] BaudOne  = BaudW'(1);
    localparam logic [2:0]      BitLast  = 3'(DataBits - 1);

    tx_state_e       state_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic            tx_q;
    logic            busy_q;

    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_rdata;
    logic            push, pop, baud_last, frame_slot, going_idle, busy_d;
    logic [LvlW-1:0] level_next;

    // Ready comes from the registered full flag only, so a same-cycle pop never admits a push.
    assign in_ready = !fifo_full && !rst;
    assign push     = in_valid && in_ready;

    assign baud_last  = (baud_q == BaudLast);
    assign frame_slot = (state_q == StIdle) || ((state_q == StStop) && baud_last);
    assign pop        = frame_slot && !fifo_empty;
    assign going_idle = frame_slot && fifo_empty;
    assign level_next = fifo_level + LvlW'(push) - LvlW'(pop);

    always_comb begin
        busy_d = 1'b1;
        if (going_idle && (level_next == '0)) busy_d = 1'b0;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q  <= StStart;
                        baud_q   <= '0;
                        shift_q  <= fifo_rdata;
                        parity_q <= ^fifo_rdata;
                        tx_q     <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        state_q <= StData;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end else begin
                        baud_q <= baud_q + BaudOne;
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == BitLast) begin
                            if (PARITY_EN != 0) begin
                                state_q <= StParity;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= StStop;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baud_q <= baud_q + BaudOne;
                    end
                end
                StParity: begin
                    if (baud_last) begin
                        state_q <= StStop;
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BaudOne;
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        // Back-to-back frames: next start bit follows the stop bit directly.
                        if (pop) begin
                            state_q  <= StStart;
                            shift_q  <= fifo_rdata;
                            parity_q <= ^fifo_rdata;
                            tx_q     <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BaudOne;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
